way_access_controller: RTL and testbench
========================================

WAY_ACCESS_CONTROLLER -- requirements
Module: way_access_controller

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 8, number of ways in the set.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-004 SHALL have parameter BLOCK_SIZE, default 32, block bytes; OFFSET_WIDTH=$clog2(BLOCK_SIZE), TAG_WIDTH=ADDRESS_WIDTH-OFFSET_WIDTH, AGE_WIDTH=$clog2(NUM_WAYS).
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid/req_ready  in/out  1/1  request handshake.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDRESS_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  read result.
- way_hit/way_valid/way_dirty/way_expired  in  NUM_WAYS each  per-way status.
- way_tag  in  NUM_WAYS*TAG_WIDTH  packed way tags.
- way_age  in  NUM_WAYS*AGE_WIDTH  packed way ages.
- way_data  in  NUM_WAYS*DATA_WIDTH  packed way data.
- way_allocate/way_wen/way_accessed  out  NUM_WAYS each  one-hot strobes.
- way_update_age  out  1  age-update strobe.
- way_accessed_age  out  AGE_WIDTH  age of accessed way.
- way_wdata/way_addr  out  DATA_WIDTH/ADDRESS_WIDTH  data/address to ways.
- mem_req_valid/mem_req_ready  out/in  1/1  backing-memory handshake.
- mem_write  out  1  1=writeback.
- mem_addr/mem_wdata  out  ADDRESS_WIDTH/DATA_WIDTH  memory request fields.
- mem_resp_valid/mem_rdata  in  1/DATA_WIDTH  refill return.

Function
REQ-006 SHALL implement FSM IDLE, LOOKUP, WRITEBACK, REFILL, ALLOC, FILL, RESPOND.
REQ-007 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready, latch write/addr/wdata and go LOOKUP.
REQ-008 LOOKUP (1 cycle): if any way_hit, select lowest-index hit; pulse way_accessed[hit], way_update_age, way_accessed_age=way_age[hit]; on write also pulse way_wen[hit], way_wdata=latched wdata; capture way_data[hit]; go RESPOND.
REQ-009 LOOKUP miss: victim = lowest-index way with way_valid=0; else lowest-index way_expired=1; else way 0; go WRITEBACK if victim valid&&dirty, else REFILL.
REQ-010 WRITEBACK SHALL hold mem_req_valid=1, mem_write=1, mem_addr={victim tag, OFFSET_WIDTH zeros}, mem_wdata=victim data, stable until mem_req_ready; then go REFILL.
REQ-011 REFILL SHALL hold mem_req_valid=1, mem_write=0, mem_addr=latched addr with offset zeroed until mem_req_ready, then wait for mem_resp_valid and capture mem_rdata; go ALLOC.
REQ-012 ALLOC SHALL pulse way_allocate[victim] for one cycle with way_addr=latched addr; go FILL.
REQ-013 FILL SHALL pulse way_wen[victim], way_accessed[victim], way_update_age, way_accessed_age=way_age[victim]; way_wdata=latched wdata on write, captured mem_rdata on read; go RESPOND.
REQ-014 RESPOND SHALL pulse resp_valid for one cycle with resp_rdata = captured data (0 for writes); go IDLE.
REQ-015 All way_* strobes SHALL be zero outside REQ-008/012/013 cycles; at most one bit per strobe vector set.
REQ-016 mem_resp_valid outside REFILL-wait SHALL be ignored; mem_req_ready while mem_req_valid=0 SHALL be ignored.
REQ-017 Read hit latency: accept at cycle t, resp_valid at t+2.

Reset
REQ-018 reset SHALL immediately force IDLE, req_ready=1 after release, and zero every other output and latched register, including mid-transaction (outstanding memory request abandoned).

Configuration
REQ-019 Macro WAY_ACCESS_CONTROLLER_STATS_EN: when defined, add outputs hit_count and miss_count (16 bits each), incremented in LOOKUP, saturating at 16'hFFFF, reset to 0; when undefined, ports and counters absent, behaviour otherwise identical.

Verification
REQ-020 Read hit way 2 (way_data[2]=32'hCAFE0001) -> resp_valid at t+2, resp_rdata=32'hCAFE0001, way_accessed=8'b00000100.
REQ-021 Write hit way 5, wdata 32'h1234 -> way_wen=8'b00100000 in LOOKUP, way_wdata=32'h1234, resp_rdata=0.
REQ-022 Read miss, way 3 invalid, others valid -> REFILL, way_allocate=8'b00001000, FILL writes mem_rdata 32'hBEEF.
REQ-023 Miss, all valid, way 6 expired and dirty, tag 0x1 -> writeback mem_addr=32'h20, then refill; mem_req_ready held low 5 cycles keeps fields stable.
REQ-024 reset asserted during REFILL wait -> outputs zero same cycle, IDLE, later mem_resp_valid ignored.
REQ-025 With STATS_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2.

Source files
------------

// File: rtl/way_access_controller.sv
// way_access_controller: request front end for one set-associative set.
// Looks up the ways, and on a miss picks a victim, writes it back if dirty,
// refills it from backing memory, then fills and acknowledges.
// Optional build macro WAY_ACCESS_CONTROLLER_STATS_EN adds hit/miss counters.
module way_access_controller #(
    parameter int NUM_WAYS      = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE),
    localparam int TAG_WIDTH    = ADDRESS_WIDTH - OFFSET_WIDTH,
    localparam int AGE_WIDTH    = $clog2(NUM_WAYS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDRESS_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    output logic                            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    input  logic [NUM_WAYS-1:0]             way_hit,
    input  logic [NUM_WAYS-1:0]             way_valid,
    input  logic [NUM_WAYS-1:0]             way_dirty,
    input  logic [NUM_WAYS-1:0]             way_expired,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]   way_tag,
    input  logic [NUM_WAYS*AGE_WIDTH-1:0]   way_age,
    input  logic [NUM_WAYS*DATA_WIDTH-1:0]  way_data,
    output logic [NUM_WAYS-1:0]             way_allocate,
    output logic [NUM_WAYS-1:0]             way_wen,
    output logic [NUM_WAYS-1:0]             way_accessed,
    output logic                            way_update_age,
    output logic [AGE_WIDTH-1:0]            way_accessed_age,
    output logic [DATA_WIDTH-1:0]           way_wdata,
    output logic [ADDRESS_WIDTH-1:0]        way_addr,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_write,
    output logic [ADDRESS_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_resp_valid,
`ifdef WAY_ACCESS_CONTROLLER_STATS_EN
    output logic [15:0]                     hit_count,
    output logic [15:0]                     miss_count,
`endif
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int IDX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_ALLOC, S_FILL, S_RESPOND
    } state_t;

    state_t state_reg, state_next;

    // Transaction context captured at accept / lookup / refill time
    logic                     wr_reg;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0]    wdata_reg;
    logic [DATA_WIDTH-1:0]    data_reg;
    logic [IDX_WIDTH-1:0]     victim_reg;
    logic [ADDRESS_WIDTH-1:0] wb_addr_reg;
    logic [DATA_WIDTH-1:0]    wb_data_reg;
    logic                     refill_wait_reg;

    // Unpacked views of the packed per-way buses
    logic [TAG_WIDTH-1:0]  tag_arr  [NUM_WAYS];
    logic [AGE_WIDTH-1:0]  age_arr  [NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_arr [NUM_WAYS];

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_unpack
            assign tag_arr[gi]  = way_tag[gi*TAG_WIDTH +: TAG_WIDTH];
            assign age_arr[gi]  = way_age[gi*AGE_WIDTH +: AGE_WIDTH];
            assign data_arr[gi] = way_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic                 hit_any, inv_any, exp_any;
    logic [IDX_WIDTH-1:0] hit_idx, inv_idx, exp_idx;
    logic [IDX_WIDTH-1:0] victim_sel;
    logic                 victim_dirty;

    // Lowest-index priority encoders for hit, invalid and expired ways
    always_comb begin
        hit_any = 1'b0;
        inv_any = 1'b0;
        exp_any = 1'b0;
        hit_idx = '0;
        inv_idx = '0;
        exp_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_WIDTH'(i);
            end
            if (!way_valid[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_WIDTH'(i);
            end
            if (way_expired[i]) begin
                exp_any = 1'b1;
                exp_idx = IDX_WIDTH'(i);
            end
        end
    end

    // Victim choice: empty way first, then an expired way, else way 0
    assign victim_sel   = inv_any ? inv_idx : (exp_any ? exp_idx : '0);
    assign victim_dirty = way_valid[victim_sel] && way_dirty[victim_sel];

    function automatic logic [NUM_WAYS-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
        logic [NUM_WAYS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // State register; reset drops any outstanding memory request at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state decision
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (req_valid) state_next = S_LOOKUP;
            S_LOOKUP:    state_next = hit_any ? S_RESPOND :
                                      (victim_dirty ? S_WRITEBACK : S_REFILL);
            S_WRITEBACK: if (mem_req_ready) state_next = S_REFILL;
            S_REFILL:    if (refill_wait_reg && mem_resp_valid) state_next = S_ALLOC;
            S_ALLOC:     state_next = S_FILL;
            S_FILL:      state_next = S_RESPOND;
            S_RESPOND:   state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state and captured context
    always_comb begin
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_rdata       = '0;
        way_allocate     = '0;
        way_wen          = '0;
        way_accessed     = '0;
        way_update_age   = 1'b0;
        way_accessed_age = '0;
        way_wdata        = '0;
        way_addr         = '0;
        mem_req_valid    = 1'b0;
        mem_write        = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (state_reg)
            S_IDLE: req_ready = 1'b1;
            S_LOOKUP: begin
                if (hit_any) begin
                    way_accessed     = onehot(hit_idx);
                    way_update_age   = 1'b1;
                    way_accessed_age = age_arr[hit_idx];
                    if (wr_reg) begin
                        way_wen   = onehot(hit_idx);
                        way_wdata = wdata_reg;
                    end
                end
            end
            S_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_write     = 1'b1;
                mem_addr      = wb_addr_reg;
                mem_wdata     = wb_data_reg;
            end
            S_REFILL: begin
                if (!refill_wait_reg) begin
                    mem_req_valid = 1'b1;
                    mem_addr      = {addr_reg[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                end
            end
            S_ALLOC: begin
                way_allocate = onehot(victim_reg);
                way_addr     = addr_reg;
            end
            S_FILL: begin
                way_wen          = onehot(victim_reg);
                way_accessed     = onehot(victim_reg);
                way_update_age   = 1'b1;
                way_accessed_age = age_arr[victim_reg];
                way_wdata        = wr_reg ? wdata_reg : data_reg;
            end
            S_RESPOND: begin
                resp_valid = 1'b1;
                resp_rdata = wr_reg ? '0 : data_reg;
            end
            default: ;
        endcase
    end

    // Capture request, lookup result, victim context and refill data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            data_reg        <= '0;
            victim_reg      <= '0;
            wb_addr_reg     <= '0;
            wb_data_reg     <= '0;
            refill_wait_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_reg          <= req_write;
                        addr_reg        <= req_addr;
                        wdata_reg       <= req_wdata;
                        data_reg        <= '0;
                        refill_wait_reg <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (hit_any) begin
                        data_reg <= data_arr[hit_idx];
                    end else begin
                        // Victim tag/data frozen here so writeback fields stay stable
                        victim_reg  <= victim_sel;
                        wb_addr_reg <= {tag_arr[victim_sel], {OFFSET_WIDTH{1'b0}}};
                        wb_data_reg <= data_arr[victim_sel];
                    end
                end
                S_REFILL: begin
                    if (!refill_wait_reg) begin
                        if (mem_req_ready) refill_wait_reg <= 1'b1;
                    end else if (mem_resp_valid) begin
                        data_reg        <= mem_rdata;
                        refill_wait_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WAY_ACCESS_CONTROLLER_STATS_EN
    logic [15:0] hit_count_reg, miss_count_reg;

    // Saturating lookup outcome counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (state_reg == S_LOOKUP) begin
            if (hit_any) begin
                if (hit_count_reg != 16'hFFFF) hit_count_reg <= hit_count_reg + 16'd1;
            end else begin
                if (miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_way_access_controller.sv
// Directed table-driven bench for way_access_controller.
module tb_way_access_controller;

    localparam int NW = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 27;
    localparam int GW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [DW-1:0]   req_wdata = '0;
    logic            resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic [NW-1:0]   way_hit = '0, way_valid = '0, way_dirty = '0, way_expired = '0;
    logic [NW*TW-1:0] way_tag = '0;
    logic [NW*GW-1:0] way_age = '0;
    logic [NW*DW-1:0] way_data = '0;
    logic [NW-1:0]   way_allocate, way_wen, way_accessed;
    logic            way_update_age;
    logic [GW-1:0]   way_accessed_age;
    logic [DW-1:0]   way_wdata;
    logic [AW-1:0]   way_addr;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic            mem_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_resp_valid = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;
`ifdef WAY_ACCESS_CONTROLLER_STATS_EN
    logic [15:0]     hit_count, miss_count;
`endif

    way_access_controller dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
        .way_expired(way_expired), .way_tag(way_tag), .way_age(way_age),
        .way_data(way_data), .way_allocate(way_allocate), .way_wen(way_wen),
        .way_accessed(way_accessed), .way_update_age(way_update_age),
        .way_accessed_age(way_accessed_age), .way_wdata(way_wdata),
        .way_addr(way_addr), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid),
`ifdef WAY_ACCESS_CONTROLLER_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  hit, valid, dirty, expired;
        logic [31:0] mem_data;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_acc, exp_wen, exp_alloc;
        logic        exp_wb;
        logic [31:0] exp_wb_addr, exp_wb_data, exp_wen_data;
        logic [2:0]  exp_age;
    } vec_t;

    vec_t vecs [8];

    task automatic set_ways(input logic [7:0] h, input logic [7:0] v,
                            input logic [7:0] d, input logic [7:0] e);
        way_hit = h; way_valid = v; way_dirty = d; way_expired = e;
    endtask

    task automatic send_req(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_write = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Scramble request inputs so only latched values can be used
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'hDEAD_DEAD; req_write = ~wr;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0]  acc, wen, alloc;
        logic [31:0] wen_data, wb_addr, wb_data, rf_addr, alloc_addr, got;
        logic [2:0]  age;
        logic        wb_seen, rf_seen, pend, done, multi;
        int          lat, exp_lat;
        acc = '0; wen = '0; alloc = '0; wen_data = '0; wb_addr = '0; wb_data = '0;
        rf_addr = '0; alloc_addr = '0; got = '0; age = '0;
        wb_seen = 0; rf_seen = 0; pend = 0; done = 0; multi = 0; lat = 0;
        set_ways(v.hit, v.valid, v.dirty, v.expired);
        send_req(v.wr, v.addr, v.wdata);
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            if ($countones(way_accessed) > 1 || $countones(way_wen) > 1 ||
                $countones(way_allocate) > 1) multi = 1;
            if (|way_accessed) begin acc |= way_accessed; age = way_accessed_age; end
            if (|way_wen) begin wen |= way_wen; wen_data = way_wdata; end
            if (|way_allocate) begin alloc |= way_allocate; alloc_addr = way_addr; end
            if (mem_req_valid && mem_write) begin
                wb_seen = 1; wb_addr = mem_addr; wb_data = mem_wdata; mem_req_ready = 1'b1;
            end else if (mem_req_valid) begin
                rf_seen = 1; rf_addr = mem_addr; mem_req_ready = 1'b1; pend = 1;
            end else if (pend) begin
                mem_resp_valid = 1'b1; mem_rdata = v.mem_data; pend = 0;
            end
            if (resp_valid) begin got = resp_rdata; lat = cyc; done = 1; end
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        check("resp_seen", 32'(done), 32'd1);
        check("resp_rdata", got, v.exp_rdata);
        check("way_accessed", 32'(acc), 32'(v.exp_acc));
        check("way_wen", 32'(wen), 32'(v.exp_wen));
        check("way_allocate", 32'(alloc), 32'(v.exp_alloc));
        check("accessed_age", 32'(age), 32'(v.exp_age));
        check("strobe_onehot", 32'(multi), 32'd0);
        check("writeback_seen", 32'(wb_seen), 32'(v.exp_wb));
        if (v.exp_wen != 0) check("way_wdata", wen_data, v.exp_wen_data);
        if (v.exp_wb) begin
            check("wb_addr", wb_addr, v.exp_wb_addr);
            check("wb_data", wb_data, v.exp_wb_data);
        end
        if (v.hit == 0) begin
            check("refill_seen", 32'(rf_seen), 32'd1);
            check("refill_addr", rf_addr, v.addr & 32'hFFFF_FFE0);
            check("alloc_addr", alloc_addr, v.addr);
            exp_lat = v.exp_wb ? 7 : 6;
        end else begin
            check("refill_seen", 32'(rf_seen), 32'd0);
            exp_lat = 2;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        $display("vec %0d: wr=%0b addr=%h rdata=%h acc=%b wen=%b alloc=%b wb=%0b lat=%0d",
                 idx, v.wr, v.addr, got, acc, wen, alloc, wb_seen, lat);
    endtask

    initial begin
        // Fixed way contents: tag i+10 (way 6 tag 1), age 7-i, data D000000i (way 2 CAFE0001)
        for (int i = 0; i < NW; i++) begin
            way_tag[i*TW +: TW]  = 27'(i + 10);
            way_age[i*GW +: GW]  = 3'(7 - i);
            way_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        end
        way_tag[6*TW +: TW]  = 27'd1;
        way_data[2*DW +: DW] = 32'hCAFE_0001;

        //          wr    addr          wdata         hit    valid  dirty  exp    mem_data      rdata         acc    wen    alloc  wb    wb_addr       wb_data       wen_data      age
        vecs[0] = '{1'b0, 32'h0000_1040, 32'h0,       8'h04, 8'hFF, 8'h00, 8'h00, 32'h0,        32'hCAFE_0001, 8'h04, 8'h00, 8'h00, 1'b0, 32'h0,        32'h0,        32'h0,        3'd5};
        vecs[1] = '{1'b1, 32'h0000_2000, 32'h1234,    8'h20, 8'hFF, 8'h00, 8'h00, 32'h0,        32'h0,         8'h20, 8'h20, 8'h00, 1'b0, 32'h0,        32'h0,        32'h1234,     3'd2};
        vecs[2] = '{1'b0, 32'h0000_3000, 32'h0,       8'h14, 8'hFF, 8'h00, 8'h00, 32'h0,        32'hCAFE_0001, 8'h04, 8'h00, 8'h00, 1'b0, 32'h0,        32'h0,        32'h0,        3'd5};
        vecs[3] = '{1'b0, 32'h1234_5678, 32'h0,       8'h00, 8'hF7, 8'hFF, 8'h00, 32'hBEEF,     32'hBEEF,      8'h08, 8'h08, 8'h08, 1'b0, 32'h0,        32'h0,        32'hBEEF,     3'd4};
        vecs[4] = '{1'b0, 32'h0000_4444, 32'h0,       8'h00, 8'hFF, 8'h40, 8'h40, 32'h5555_AAAA, 32'h5555_AAAA, 8'h40, 8'h40, 8'h40, 1'b1, 32'h20,      32'hD000_0006, 32'h5555_AAAA, 3'd1};
        vecs[5] = '{1'b1, 32'h0000_5500, 32'hABCD,    8'h00, 8'hFF, 8'h01, 8'h00, 32'h7777_7777, 32'h0,         8'h01, 8'h01, 8'h01, 1'b1, 32'h140,     32'hD000_0000, 32'hABCD,     3'd7};
        vecs[6] = '{1'b0, 32'h0000_6600, 32'h0,       8'h00, 8'hFF, 8'h00, 8'h0C, 32'h1234_0000, 32'h1234_0000, 8'h04, 8'h04, 8'h04, 1'b0, 32'h0,        32'h0,        32'h1234_0000, 3'd5};
        vecs[7] = '{1'b0, 32'h0000_7700, 32'h0,       8'h00, 8'hCF, 8'h10, 8'h01, 32'h0BAD_F00D, 32'h0BAD_F00D, 8'h10, 8'h10, 8'h10, 1'b0, 32'h0,        32'h0,        32'h0BAD_F00D, 3'd3};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_way_strobes", 32'({way_allocate, way_wen, way_accessed}), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
`ifdef WAY_ACCESS_CONTROLLER_STATS_EN
            if (i == 4) begin
                check("hit_count", 32'(hit_count), 32'd3);
                check("miss_count", 32'(miss_count), 32'd2);
            end
`endif
        end

        // Writeback stall: fields must hold while mem_req_ready stays low
        set_ways(8'h00, 8'hFF, 8'h40, 8'h40);
        send_req(1'b0, 32'h0000_4444, 32'h0);
        begin
            int k;
            for (k = 0; k < 10 && !mem_req_valid; k++) @(negedge clk);
            check("stall_wb_start", 32'(mem_req_valid), 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(mem_req_valid), 32'd1);
            check("stall_write", 32'(mem_write), 32'd1);
            check("stall_addr", mem_addr, 32'h20);
            check("stall_wdata", mem_wdata, 32'hD000_0006);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("refill_valid", 32'(mem_req_valid), 32'd1);
        check("refill_write", 32'(mem_write), 32'd0);
        check("refill_addr_stall", mem_addr, 32'h0000_4440);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("refill_wait_idle_bus", 32'(mem_req_valid), 32'd0);
        $display("stall sequence: writeback held 5 cycles, refill accepted");

        // Reset during refill wait: immediate return to idle, late response ignored
        reset = 1'b1;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("arst_outputs", mem_addr | resp_rdata | way_wdata | 32'({way_allocate, way_wen, way_accessed}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h9999_9999; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        begin
            logic seen;
            seen = 0;
            for (int k = 0; k < 5; k++) begin
                if (resp_valid || mem_req_valid || |way_allocate || |way_wen || !req_ready) seen = 1;
                @(negedge clk);
            end
            check("post_reset_quiet", 32'(seen), 32'd0);
        end
        $display("reset sequence: refill abandoned, late response ignored");

        // Normal operation resumes after the abandoned transaction
        run_vec(vecs[0], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
